// File: rtl/flit_link_tx.sv
// flit_link_tx - output-side link transmitter for one router port.
//
// Pulls flits out of the local FIFO whenever it is non-empty and the
// downstream buffer has a free slot (credit). Each returned flit is registered
// onto the outgoing link one cycle after the FIFO presents it. A small framing
// FSM follows head/body/tail/single sequencing and raises a sticky error on
// malformed packets. Framing errors never stall the link.
//
// Ports:
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   fifo_emp      : local FIFO empty flag
//   fifo_rd       : local FIFO read strobe (combinational)
//   fifo_data     : local FIFO read data, valid the cycle after fifo_rd
//   link_valid    : outgoing flit valid, one cycle per flit
//   link_flit     : outgoing flit (holds its last value when not valid)
//   credit_ret    : one downstream credit returned this cycle
//   credit_cnt    : credits currently available
//   pkt_active    : a head has been sent and its tail has not
//   err           : sticky protocol error (framing or credit overflow)
//
// Optional build macro FLIT_LINK_TX_STATS_EN adds:
//   flit_cnt      : flits sent, wraps at 2^16
//   pkt_cnt       : tails/singles sent, wraps at 2^16

module flit_link_tx #(
  parameter int W       = 16,
  parameter int CREDITS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fifo_emp,
  output logic         fifo_rd,
  input  logic [W-1:0] fifo_data,
  output logic         link_valid,
  output logic [W-1:0] link_flit,
  input  logic         credit_ret,
  output logic [3:0]   credit_cnt,
  output logic         pkt_active,
  output logic         err
`ifdef FLIT_LINK_TX_STATS_EN
  ,
  output logic [15:0]  flit_cnt,
  output logic [15:0]  pkt_cnt
`endif
);

  localparam logic [3:0] C_MAX = 4'(CREDITS);

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_TAIL   = 2'b01;
  localparam logic [1:0] T_HEAD   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PKT  = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [3:0]     r_credit;
  logic [3:0]     w_credit_nxt;
  logic           r_rd_pend_p0;
  logic           r_link_valid_p1;
  logic [W-1:0]   r_link_flit_p1;
  logic           r_err;
  logic           w_rd;
  logic           w_credit_over;
  logic           w_frame_err;
  logic [1:0]     w_type;

  assign w_rd   = !rst && !fifo_emp && (r_credit != 4'd0);
  assign w_type = fifo_data[W-1:W-2];

  // A return with the pool already full and no read to absorb it means
  // downstream handed back a credit it never had.
  assign w_credit_over = credit_ret && !w_rd && (r_credit == C_MAX);

  // Credits are reserved when the read issues, not when the flit leaves.
  always_comb begin
    w_credit_nxt = r_credit;
    unique case ({w_rd, credit_ret})
      2'b10:   w_credit_nxt = r_credit - 4'd1;
      2'b01:   if (!w_credit_over) w_credit_nxt = r_credit + 4'd1;
      default: w_credit_nxt = r_credit;
    endcase
  end

  // Framing: evaluated on the flit being captured this cycle. A head or
  // single arriving mid-packet restarts framing as if it opened a new one.
  always_comb begin
    w_state_nxt = r_state;
    w_frame_err = 1'b0;
    if (r_rd_pend_p0) begin
      unique case (r_state)
        S_IDLE: begin
          unique case (w_type)
            T_HEAD:   w_state_nxt = S_PKT;
            T_SINGLE: w_state_nxt = S_IDLE;
            default:  w_frame_err = 1'b1;
          endcase
        end
        S_PKT: begin
          unique case (w_type)
            T_BODY:   w_state_nxt = S_PKT;
            T_TAIL:   w_state_nxt = S_IDLE;
            T_HEAD: begin
              w_frame_err = 1'b1;
              w_state_nxt = S_PKT;
            end
            T_SINGLE: begin
              w_frame_err = 1'b1;
              w_state_nxt = S_IDLE;
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_credit        <= C_MAX;
      r_rd_pend_p0    <= 1'b0;
      r_link_valid_p1 <= 1'b0;
      r_link_flit_p1  <= '0;
      r_err           <= 1'b0;
    end else begin
      // stage p0: read issued, FIFO presents data next cycle
      r_rd_pend_p0    <= w_rd;
      // stage p1: FIFO data registered onto the link
      r_link_valid_p1 <= r_rd_pend_p0;
      if (r_rd_pend_p0) r_link_flit_p1 <= fifo_data;
      r_state         <= w_state_nxt;
      r_credit        <= w_credit_nxt;
      r_err           <= r_err | w_frame_err | w_credit_over;
    end
  end

`ifdef FLIT_LINK_TX_STATS_EN
  logic [15:0] r_flit_cnt;
  logic [15:0] r_pkt_cnt;

  // Counted on the capture edge, so the counts include the flit on the link.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flit_cnt <= 16'd0;
      r_pkt_cnt  <= 16'd0;
    end else if (r_rd_pend_p0) begin
      r_flit_cnt <= r_flit_cnt + 16'd1;
      if (w_type[0]) r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end

  assign flit_cnt = r_flit_cnt;
  assign pkt_cnt  = r_pkt_cnt;
`endif

  assign fifo_rd    = w_rd;
  assign link_valid = r_link_valid_p1;
  assign link_flit  = r_link_flit_p1;
  assign credit_cnt = r_credit;
  assign pkt_active = (r_state == S_PKT);
  assign err        = r_err;

endmodule
